// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter serialising instruction fetches and load/stores onto a byte-wide RAM port.
//   clk, rst (async active-low), rdy (global enable, low = freeze), flush (abort reads)
//   IF_req_valid/IF_pc -> MC_input_valid/MC_inst : 4-byte little-endian fetch
//   LSB_req_valid/LSB_is_store/LSB_size/LSB_addr/LSB_wdata -> LSB_done/LSB_rdata : 1/2/4-byte load or store
//   mem_din/mem_dout/mem_a/mem_wr : RAM byte port; io_buffer_full stalls store bytes
module mem_arbiter #(
  parameter int AddrWidth = 32,
  parameter int InstWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 IF_req_valid,
  input  logic [AddrWidth-1:0] IF_pc,
  output logic                 MC_input_valid,
  output logic [InstWidth-1:0] MC_inst,
  input  logic                 LSB_req_valid,
  input  logic                 LSB_is_store,
  input  logic [1:0]           LSB_size,
  input  logic [AddrWidth-1:0] LSB_addr,
  input  logic [InstWidth-1:0] LSB_wdata,
  output logic                 LSB_done,
  output logic [InstWidth-1:0] LSB_rdata,
  input  logic                 flush,
  input  logic [7:0]           mem_din,
  output logic [7:0]           mem_dout,
  output logic [AddrWidth-1:0] mem_a,
  output logic                 mem_wr,
  input  logic                 io_buffer_full
);
  typedef enum logic [1:0] {IDLE, IF_READ, LS_READ, LS_WRITE} state_e;
  state_e               state_q;
  logic [2:0]           cnt_q;
  logic [1:0]           nlast_q;
  logic                 last_grant_q;
  logic [AddrWidth-1:0] mem_a_q;
  logic [7:0]           mem_dout_q;
  logic                 mem_wr_q;
  logic [InstWidth-1:0] wdata_q;
  logic [InstWidth-1:0] rbuf_q;
  logic [InstWidth-1:0] mc_inst_q;
  logic [InstWidth-1:0] lsb_rdata_q;
  logic                 mc_valid_q;
  logic                 lsb_done_q;
  logic                 if_ok_d;
  logic                 ls_ok_d;
  logic                 grant_ls_d;
  logic                 grant_if_d;
  logic                 last_byte_d;
  logic [1:0]           ls_nlast_d;
  logic [InstWidth-1:0] asm_d;
  // A requester whose done pulse is still high has already been served this round.
  assign if_ok_d     = IF_req_valid && !mc_valid_q;
  assign ls_ok_d     = LSB_req_valid && !lsb_done_q;
  // last_grant_q = 1 means the LSB won last time, so the fetch side gets priority.
  assign grant_ls_d  = ls_ok_d && (!if_ok_d || !last_grant_q);
  assign grant_if_d  = if_ok_d && !grant_ls_d;
  assign ls_nlast_d  = LSB_size == 2'b00 ? 2'd0 : LSB_size == 2'b01 ? 2'd1 : 2'd3;
  assign last_byte_d = cnt_q == {1'b0, nlast_q};
  // rbuf_q is cleared at grant, so shorter loads come out zero-extended.
  assign asm_d       = rbuf_q | (InstWidth'(mem_din) << {cnt_q, 3'b000});
  assign MC_input_valid = mc_valid_q;
  assign MC_inst        = mc_inst_q;
  assign LSB_done       = lsb_done_q;
  assign LSB_rdata      = lsb_rdata_q;
  assign mem_a          = mem_a_q;
  assign mem_dout       = mem_dout_q;
  // Write strobe is masked immediately by freeze or IO back-pressure so no byte is issued twice or lost.
  assign mem_wr         = mem_wr_q && rdy && !io_buffer_full;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      nlast_q      <= '0;
      last_grant_q <= 1'b0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      mc_inst_q    <= '0;
      lsb_rdata_q  <= '0;
      mc_valid_q   <= 1'b0;
      lsb_done_q   <= 1'b0;
    end else begin
      mc_valid_q <= 1'b0;
      lsb_done_q <= 1'b0;
      if (rdy) begin
        case (state_q)
          IDLE: begin
            if (!flush && (grant_ls_d || grant_if_d)) begin
              cnt_q        <= '0;
              rbuf_q       <= '0;
              last_grant_q <= grant_ls_d;
              mem_a_q      <= grant_ls_d ? LSB_addr : IF_pc;
              nlast_q      <= grant_ls_d ? ls_nlast_d : 2'd3;
              mem_wr_q     <= grant_ls_d && LSB_is_store;
              state_q      <= !grant_ls_d ? IF_READ : LSB_is_store ? LS_WRITE : LS_READ;
              if (grant_ls_d && LSB_is_store) begin
                mem_dout_q <= LSB_wdata[7:0];
                wdata_q    <= LSB_wdata >> 8;
              end
            end
          end
          IF_READ, LS_READ: begin
            if (flush) begin
              state_q <= IDLE;
            end else if (last_byte_d) begin
              state_q <= IDLE;
              if (state_q == IF_READ) begin
                mc_valid_q <= 1'b1;
                mc_inst_q  <= asm_d;
              end else begin
                lsb_done_q  <= 1'b1;
                lsb_rdata_q <= asm_d;
              end
            end else begin
              rbuf_q  <= asm_d;
              cnt_q   <= cnt_q + 3'd1;
              mem_a_q <= mem_a_q + 1'b1;
            end
          end
          LS_WRITE: begin
            if (!io_buffer_full) begin
              if (last_byte_d) begin
                mem_wr_q   <= 1'b0;
                lsb_done_q <= 1'b1;
                state_q    <= IDLE;
              end else begin
                cnt_q      <= cnt_q + 3'd1;
                mem_a_q    <= mem_a_q + 1'b1;
                mem_dout_q <= wdata_q[7:0];
                wdata_q    <= wdata_q >> 8;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AddrWidth, 32, address width.
REQ-002 SHALL have parameter InstWidth, 32, instruction and data word width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port rdy  in  1  global enable; low = freeze.
REQ-006 SHALL have port IF_req_valid  in  1  instruction-fetch request.
REQ-007 SHALL have port IF_pc  in  AddrWidth  fetch address.
REQ-008 SHALL have port MC_input_valid  out  1  one-cycle fetch-done pulse.
REQ-009 SHALL have port MC_inst  out  InstWidth  fetched word.
REQ-010 SHALL have port LSB_req_valid  in  1  load/store request.
REQ-011 SHALL have port LSB_is_store  in  1  1 = store, 0 = load.
REQ-012 SHALL have port LSB_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-013 SHALL have port LSB_addr  in  AddrWidth  load/store base address.
REQ-014 SHALL have port LSB_wdata  in  InstWidth  store data.
REQ-015 SHALL have port LSB_done  out  1  one-cycle load/store-done pulse.
REQ-016 SHALL have port LSB_rdata  out  InstWidth  load data, zero-extended.
REQ-017 SHALL have port flush  in  1  misprediction clear.
REQ-018 SHALL have port mem_din  in  8  RAM read byte.
REQ-019 SHALL have port mem_dout  out  8  RAM write byte.
REQ-020 SHALL have port mem_a  out  AddrWidth  RAM byte address.
REQ-021 SHALL have port mem_wr  out  1  1 = write.
REQ-022 SHALL have port io_buffer_full  in  1  IO write back-pressure.

Function
REQ-023 SHALL implement the FSM states IDLE, IF_READ, LS_READ and LS_WRITE, with a 3-bit byte counter and a last_grant bit.
REQ-024 SHALL, when a request is sampled in IDLE at edge E0, drive the transaction with N bytes (IF: 4; LSB: 1/2/4); byte k uses address base+k, little-endian.
REQ-025 SHALL, for reads, drive mem_a=base+k with mem_wr=0 after edge Ek (k=0..N-1), sample mem_din at E(k+1) as byte k, and at EN register the assembled data with the done pulse high for exactly one cycle while returning to IDLE.
REQ-026 SHALL, for writes, drive mem_a=base+k, mem_dout=wdata[8k+7:8k] and mem_wr=1 after Ek, and at EN drop mem_wr, pulse LSB_done and return to IDLE.
REQ-027 SHALL, in LS_WRITE while io_buffer_full=1, drive mem_wr=0 and hold the counter and address, so no byte is lost.
REQ-028 SHALL, when both requests are valid in IDLE, grant the requester opposite to last_grant (round-robin), and update last_grant on each grant.
REQ-029 SHALL, in IDLE, ignore a requester whose done pulse is high in that cycle, so no duplicate grant occurs.
REQ-030 SHALL, on flush=1 in IF_READ or LS_READ, abort to IDLE at the next edge with no done pulse.
REQ-031 SHALL ignore flush in LS_WRITE; a committed store completes.
REQ-032 SHALL grant nothing in a cycle in IDLE with flush=1.
REQ-033 SHALL, while rdy=0, hold all state and counters, drive mem_wr=0, and produce no done pulses; operation resumes exactly where it stopped.
REQ-034 SHALL hold MC_inst and LSB_rdata stable between transactions; a done pulse occurs only with fresh data.

Reset
REQ-035 SHALL, while rst=0, immediately force state IDLE, counter 0, last_grant 0, and drive all outputs (mem_a, mem_dout, mem_wr, MC_input_valid, MC_inst, LSB_done, LSB_rdata) to 0, including mid-transaction.
REQ-036 SHALL, after rst releases, accept a new request at the first rising edge with rdy=1.

Verification
REQ-037 SHALL verify: IF_pc=0x1000, memory bytes 13 05 00 00 -> mem_a steps 0x1000..0x1003, MC_inst=0x00000513, MC_input_valid high one cycle at E4.
REQ-038 SHALL verify: IF and LSB load valid together at E0 with last_grant=0 -> LSB served first, LSB_done at E4; IF granted next, MC_input_valid at E9.
REQ-039 SHALL verify: store half 0xBEEF to 0x30000 with io_buffer_full high for 2 cycles at byte 1 -> bytes EF, BE written once each, LSB_done 2 cycles late.
REQ-040 SHALL verify: flush at cycle 2 of IF_READ -> IDLE next edge, no MC_input_valid; a following request is served normally.
REQ-041 SHALL verify: rdy low 3 cycles mid-load -> mem_a frozen, result identical, done delayed by 3 cycles.
REQ-042 SHALL verify: rst low mid-store -> mem_wr=0 immediately, all outputs 0, state IDLE.
